// File: rtl/vga_timing_pkg.sv
// Shared mode constants and elaboration helpers for the VGA raster timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          h_pol;
        bit          v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_72 = '{
        h_active: 640, h_fp: 24, h_sync: 40, h_bp: 128,
        v_active: 480, v_fp: 9,  v_sync: 3,  v_bp: 28,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // A total of exactly 2^cw is fine: the last count is still 2^cw-1.
    function automatic bit width_ok(input int total, input int cw);
        return longint'(total) <= (longint'(1) << cw);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational sync/active decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 24,
    parameter int SYNC   = 40,
    parameter int BP     = 128,
    parameter bit POL    = 1'b0,
    parameter int CW     = 10
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync_lvl,
    output logic          active
);

    localparam int TOTAL = h_total(ACTIVE, FP, SYNC, BP);

    // One extra bit so a sync window ending exactly at 2^CW still compares correctly.
    localparam logic [CW:0] LAST       = (CW+1)'(TOTAL - 1);
    localparam logic [CW:0] ACT_END    = (CW+1)'(ACTIVE);
    localparam logic [CW:0] SYNC_BEGIN = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0] SYNC_END   = (CW+1)'(ACTIVE + FP + SYNC);

    logic [CW:0] count_x;

    assign count_x  = {1'b0, count};
    assign wrap     = advance && (count_x == LAST);
    assign active   = count_x < ACT_END;
    assign sync_lvl = ((count_x >= SYNC_BEGIN) && (count_x < SYNC_END)) ? POL : ~POL;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with registered, mutually aligned outputs.
// Optional next-pixel prefetch outputs are enabled with VGA_TIMING_PREFETCH_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = MODE_640X480_72.h_active,
    parameter int H_FP       = MODE_640X480_72.h_fp,
    parameter int H_SYNC     = MODE_640X480_72.h_sync,
    parameter int H_BP       = MODE_640X480_72.h_bp,
    parameter int V_ACTIVE   = MODE_640X480_72.v_active,
    parameter int V_FP       = MODE_640X480_72.v_fp,
    parameter int V_SYNC     = MODE_640X480_72.v_sync,
    parameter int V_BP       = MODE_640X480_72.v_bp,
    parameter bit H_SYNC_POL = MODE_640X480_72.h_pol,
    parameter bit V_SYNC_POL = MODE_640X480_72.v_pol,
    parameter int CW         = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic               activevideo,
    output logic [CW-1:0]      x_px,
    output logic [CW-1:0]      y_px,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank,
    output logic [FRAME_W-1:0] frame_count
`ifdef VGA_TIMING_PREFETCH_EN
    ,
    output logic [CW-1:0]      x_next,
    output logic [CW-1:0]      y_next,
    output logic               active_next
`endif
);

    if (!width_ok(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP), CW) ||
        !width_ok(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP), CW)) begin : g_width_err
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2^CW");
    end

    logic [CW-1:0]      hc;
    logic [CW-1:0]      vc;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_sync_lvl;
    logic               v_sync_lvl;
    logic               h_active;
    logic               v_active;
    logic [FRAME_W-1:0] frame_cnt;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL),
        .CW     (CW)
    ) u_h_axis (
        .px_clk   (px_clk),
        .reset    (reset),
        .advance  (enable),
        .count    (hc),
        .wrap     (h_wrap),
        .sync_lvl (h_sync_lvl),
        .active   (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL),
        .CW     (CW)
    ) u_v_axis (
        .px_clk   (px_clk),
        .reset    (reset),
        .advance  (h_wrap),
        .count    (vc),
        .wrap     (v_wrap),
        .sync_lvl (v_sync_lvl),
        .active   (v_active)
    );

    // frame_cnt runs one pixel ahead of frame_count so both flip with frame_start.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            x_px        <= '0;
            y_px        <= '0;
            activevideo <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            frame_count <= '0;
            frame_cnt   <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (enable) begin
                x_px        <= hc;
                y_px        <= vc;
                activevideo <= h_active && v_active;
                line_start  <= (hc == '0);
                frame_start <= (hc == '0) && (vc == '0);
                vblank      <= ~v_active;
                hsync       <= h_sync_lvl;
                vsync       <= v_sync_lvl;
                frame_count <= frame_cnt;
                if (v_wrap) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`ifdef VGA_TIMING_PREFETCH_EN
    // The counters already hold the pixel the next enabled cycle will present.
    assign x_next      = hc;
    assign y_next      = vc;
    assign active_next = h_active && v_active;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench for vga_timing_gen: a small-mode and a default-mode instance
// checked every cycle against a pixel-index arithmetic model.
module tb_vga_timing_gen;

    logic px_clk = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;

    always #5 px_clk = ~px_clk;

    // small mode: H 8/2/3/1 (total 14, hsync active-high), V 4/1/1/1 (total 7)
    logic       s_hs, s_vs, s_av, s_ls, s_fs, s_vb;
    logic [3:0] s_x, s_y;
    logic [7:0] s_fc;
    logic       d_hs, d_vs, d_av, d_ls, d_fs, d_vb;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
`ifdef VGA_TIMING_PREFETCH_EN
    logic [3:0] s_xn, s_yn;
    logic       s_an;
    logic [9:0] d_xn, d_yn;
    logic       d_an;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CW(4), .FRAME_W(8)
    ) dut_s (
        .px_clk(px_clk), .reset(reset), .enable(enable),
        .hsync(s_hs), .vsync(s_vs), .activevideo(s_av),
        .x_px(s_x), .y_px(s_y), .line_start(s_ls), .frame_start(s_fs),
        .vblank(s_vb), .frame_count(s_fc)
`ifdef VGA_TIMING_PREFETCH_EN
        , .x_next(s_xn), .y_next(s_yn), .active_next(s_an)
`endif
    );

    vga_timing_gen dut_d (
        .px_clk(px_clk), .reset(reset), .enable(enable),
        .hsync(d_hs), .vsync(d_vs), .activevideo(d_av),
        .x_px(d_x), .y_px(d_y), .line_start(d_ls), .frame_start(d_fs),
        .vblank(d_vb), .frame_count(d_fc)
`ifdef VGA_TIMING_PREFETCH_EN
        , .x_next(d_xn), .y_next(d_yn), .active_next(d_an)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int x, y, fc, xn, yn;
        bit hs, vs, av, ls, fs, vb, an;
    } exp_t;

    // Presented pixel = (enabled edges since reset) - 1, laid out row-major over the raster.
    function automatic exp_t model(input longint n, input bit last_en,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb,
                                   input bit hp, input bit vp);
        exp_t   e;
        longint ht, vt, p;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        e.xn = int'(n % ht);
        e.yn = int'((n / ht) % vt);
        e.an = (e.xn < ha) && (e.yn < va);
        if (n == 0) begin
            e.x = 0; e.y = 0; e.fc = 0;
            e.av = 0; e.ls = 0; e.fs = 0; e.vb = 0;
            e.hs = !hp; e.vs = !vp;
        end else begin
            p    = n - 1;
            e.x  = int'(p % ht);
            e.y  = int'((p / ht) % vt);
            e.fc = int'((p / (ht * vt)) % 256);
            e.av = (e.x < ha) && (e.y < va);
            e.vb = e.y >= va;
            e.hs = (e.x >= ha + hf && e.x < ha + hf + hs) ? hp : !hp;
            e.vs = (e.y >= va + vf && e.y < va + vf + vs) ? vp : !vp;
            e.ls = last_en && (e.x == 0);
            e.fs = e.ls && (e.y == 0);
        end
        return e;
    endfunction

    longint n_en    = 0;
    bit     last_en = 1'b0;

    always @(posedge px_clk) begin
        if (reset) begin
            n_en    <= 0;
            last_en <= 1'b0;
        end else begin
            last_en <= enable;
            if (enable) n_en <= n_en + 1;
        end
    end

    always @(negedge px_clk) begin
        exp_t e;
        e = model(n_en, last_en, 8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        chk("s_x", s_x, e.x);           chk("s_y", s_y, e.y);
        chk("s_hsync", s_hs, e.hs);     chk("s_vsync", s_vs, e.vs);
        chk("s_active", s_av, e.av);    chk("s_vblank", s_vb, e.vb);
        chk("s_line_start", s_ls, e.ls); chk("s_frame_start", s_fs, e.fs);
        chk("s_frame_count", s_fc, e.fc);
`ifdef VGA_TIMING_PREFETCH_EN
        chk("s_x_next", s_xn, e.xn); chk("s_y_next", s_yn, e.yn); chk("s_active_next", s_an, e.an);
`endif
        e = model(n_en, last_en, 640, 24, 40, 128, 480, 9, 3, 28, 1'b0, 1'b0);
        chk("d_x", d_x, e.x);           chk("d_y", d_y, e.y);
        chk("d_hsync", d_hs, e.hs);     chk("d_vsync", d_vs, e.vs);
        chk("d_active", d_av, e.av);    chk("d_vblank", d_vb, e.vb);
        chk("d_line_start", d_ls, e.ls); chk("d_frame_start", d_fs, e.fs);
        chk("d_frame_count", d_fc, e.fc);
`ifdef VGA_TIMING_PREFETCH_EN
        chk("d_x_next", d_xn, e.xn); chk("d_y_next", d_yn, e.yn); chk("d_active_next", d_an, e.an);
`endif
    end

    initial begin
        int d_last_ls, s_last_fs, s_last_ls, d_hlow, waited;
        bit found;

        reset = 1'b1;
        repeat (5) begin
            @(negedge px_clk);
            enable = 1'($urandom_range(0, 1));
        end
        @(negedge px_clk);
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge px_clk);
        // pixel 0 is on the outputs
        chk("pin_first_x", s_x, 0);       chk("pin_first_y", s_y, 0);
        chk("pin_first_active", s_av, 1); chk("pin_first_ls", s_ls, 1);
        chk("pin_first_fs", d_fs, 1);

        d_last_ls = 0; s_last_fs = 0; d_hlow = 0;
        for (int i = 1; i <= 257 * 98; i++) begin
            @(negedge px_clk);
            if (i < 2 * 832) begin
                if (d_hs == 1'b0) d_hlow++;
                if (d_ls) begin
                    chk("pin_d_line_period", i - d_last_ls, 832);
                    d_last_ls = i;
                end
            end
            if (s_fs) begin
                chk("pin_s_frame_period", i - s_last_fs, 98);
                s_last_fs = i;
            end
            if (i == 2 * 832 - 1) chk("pin_d_hsync_low_cycles", d_hlow, 80);
            if (i == 256 * 98) chk("pin_fc_wrap", s_fc, 0);
        end
        chk("pin_fc_257", s_fc, 1);
        chk("pin_fs_257", s_fs, 1);

        // alternate enable: line period doubles to 28 px_clk
        s_last_ls = -1;
        for (int i = 0; i < 8 * 28; i++) begin
            @(negedge px_clk);
            if (s_ls) begin
                if (s_last_ls >= 0) chk("pin_s_line_period_half_rate", i - s_last_ls, 28);
                s_last_ls = i;
            end
            enable = (i % 2) != 0;
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge px_clk);
            enable = $urandom_range(0, 3) != 0;
            reset  = $urandom_range(0, 499) == 0;
        end

        @(negedge px_clk);
        reset  = 1'b0;
        enable = 1'b1;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 200) begin
            @(negedge px_clk);
            waited++;
            if (s_x == 4'd5 && s_y == 4'd3) found = 1'b1;
        end
        chk("pin_reach_5_3", found, 1);
        reset = 1'b1;
        @(negedge px_clk);
        chk("pin_rst_x", s_x, 0);        chk("pin_rst_y", s_y, 0);
        chk("pin_rst_active", s_av, 0);  chk("pin_rst_hsync_pol1", s_hs, 0);
        chk("pin_rst_d_hsync", d_hs, 1); chk("pin_rst_fc", s_fc, 0);
        reset = 1'b0;
        @(negedge px_clk);
        chk("pin_post_rst_fs", s_fs, 1); chk("pin_post_rst_active", s_av, 1);
        chk("pin_post_rst_x", s_x, 0);   chk("pin_post_rst_fc", s_fc, 0);
        repeat (20) @(negedge px_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
